timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port addr, input, 32 bits: byte address from the CPU M-stage; only bits [3:2] are decoded.
REQ-004 SHALL have port we, input, 1 bit: write strobe, qualified by the bridge select.
REQ-005 SHALL have port be, input, 4 bits: byte enables from the CPU store path.
REQ-006 SHALL have port wdata, input, 32 bits: store data, taken after the rt bypass.
REQ-007 SHALL have port rdata, output, 32 bits: combinational read data.
REQ-008 SHALL have port irq, output, 1 bit: level interrupt request to the CPU.

Function
REQ-009 SHALL decode the register map on addr[3:2] as follows.
- 0 = CTRL: bit0 EN, bits[2:1] MODE, bit3 IM; all other bits read 0.
- 1 = PRESET: read/write, 32 bits.
- 2 = COUNT: read-only.
- 3 = reads 0.
REQ-010 SHALL accept a write only when we=1 and be=4'hF; partial-word writes and writes to COUNT or offset 3 SHALL be ignored.
REQ-011 SHALL drive rdata combinationally from addr with zero-cycle latency and no side effects.
REQ-012 SHALL implement the FSM IDLE, LOAD, CNT, INT, with these transitions.
- IDLE -> LOAD when EN=1.
- LOAD: COUNT <= PRESET, then -> CNT.
- CNT: COUNT decrements by 1 per cycle.
REQ-013 SHALL, in CNT, go to INT with COUNT <= 0 when COUNT is 1; when COUNT is 0 (PRESET=0), go to INT without decrementing.
REQ-014 SHALL, in state CNT or LOAD with EN=0, go to IDLE the next cycle with COUNT frozen.
REQ-015 SHALL, on entering INT, set the sticky flag PEND.
REQ-016 SHALL, from INT, behave per MODE.
- MODE=00 (one-shot): clear EN, -> IDLE.
- MODE=01 (auto-reload): -> LOAD.
- MODE=1x: treated as 00.
REQ-017 SHALL drive irq = PEND & IM.
REQ-018 SHALL clear PEND on any accepted write to CTRL or PRESET.
REQ-019 SHALL give an accepted CPU write to CTRL priority over the FSM's clear of EN in the same cycle.
REQ-020 SHALL apply a PRESET write during CNT only at the next LOAD.
REQ-021 SHALL, if a PEND set and a PEND clear occur in the same cycle, leave PEND set.
REQ-022 SHALL, with PRESET=P>=1 and EN written at edge N, load at edge N+1, reach COUNT=0 and INT at edge N+P+1, and assert irq after that edge.

Reset
REQ-023 SHALL, while reset=0 (asynchronous), force the following regardless of clk:
- state IDLE;
- CTRL, PRESET, COUNT and PEND = 0;
- irq = 0.
REQ-024 SHALL abort any count in progress on reset assertion; the first edge after release SHALL observe IDLE.

Configuration
REQ-025 SHALL gate the interrupt feature with macro TIMER_COUNTER_IRQ_EN.
- Defined: REQ-015 to REQ-018 and REQ-021 apply as written.
- Undefined: irq tied 0, PEND not implemented, CTRL bit3 ignored and read as 0, count/reload behaviour unchanged.

Structure
REQ-026 SHALL place the following in shared package timer_pkg, reusable by the system bridge: FSM state encodings, register offsets (0x0/0x4/0x8), CTRL bit positions, MODE codes.
REQ-027 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-028 SHALL cover a one-shot count: PRESET=5, then CTRL=0x9 -> irq rises 6 edges after the CTRL write, COUNT reads 0, EN reads 0, state IDLE; irq stays high until the next CTRL write.
REQ-029 SHALL cover auto-reload: PRESET=3, CTRL=0xB -> irq after 4 edges; COUNT then reloads to 3 and repeats every 5 edges; a PRESET write clears irq.
REQ-030 SHALL cover disable mid-count: PRESET=100; write CTRL=0 when COUNT=40 -> COUNT holds 40, no irq; re-enabling reloads 100.
REQ-031 SHALL cover illegal writes: be=4'h3 write to PRESET, and a write to COUNT -> both ignored; readback unchanged.
REQ-032 SHALL cover zero preset: PRESET=0, CTRL=0x9 -> INT 2 edges after the write.
REQ-033 SHALL cover async reset: reset driven low mid-count between edges -> rdata of all registers reads 0 and irq=0 immediately.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// ============================================================================
// Module : timer_pkg
// Desc   : Shared timer definitions (FSM states, register map, CTRL fields, MODE codes)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [31:0] C_OFF_CTRL   = 32'h0;
  localparam logic [31:0] C_OFF_PRESET = 32'h4;
  localparam logic [31:0] C_OFF_COUNT  = 32'h8;

  localparam logic [1:0] C_SEL_CTRL   = C_OFF_CTRL[3:2];
  localparam logic [1:0] C_SEL_PRESET = C_OFF_PRESET[3:2];
  localparam logic [1:0] C_SEL_COUNT  = C_OFF_COUNT[3:2];

  localparam int C_CTRL_EN       = 0;
  localparam int C_CTRL_MODE_LSB = 1;
  localparam int C_CTRL_MODE_MSB = 2;
  localparam int C_CTRL_IM       = 3;

  localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] C_MODE_RELOAD  = 2'b01;

  function automatic logic [31:0] ctrl_pack(input logic en, input logic [1:0] mode,
                                            input logic im);
    logic [31:0] v;
    v = '0;
    v[C_CTRL_EN] = en;
    v[C_CTRL_MODE_MSB:C_CTRL_MODE_LSB] = mode;
    v[C_CTRL_IM] = im;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_counter_if.sv
// ============================================================================
// Module : timer_counter_if
// Desc   : CPU-side register bus and interrupt line of the timer
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output we, output be, output wdata,
                  input rdata, input irq);
  modport slave  (input addr, input we, input be, input wdata,
                  output rdata, output irq);
endinterface

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// Module : timer_counter
// Desc   : Down-counting timer with one-shot/auto-reload modes and a level IRQ.
//          Interrupt logic (PEND, IM, irq) exists only with TIMER_COUNTER_IRQ_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_counter
  import timer_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      reset,
  timer_counter_if.slave bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_en;
  logic [1:0]  r_mode;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        w_fsm_clr_en;
  logic [1:0]  w_sel;
  logic        w_wr_ok;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_en_eff;
  logic        w_im_rd;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_sel         = bus.addr[3:2];
  assign w_unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
  assign w_wr_ok       = bus.we && (bus.be == 4'hF);
  assign w_wr_ctrl     = w_wr_ok && (w_sel == C_SEL_CTRL);
  assign w_wr_preset   = w_wr_ok && (w_sel == C_SEL_PRESET);

  // The FSM reacts to an EN write in the same cycle, so start/stop take effect at the write edge.
  assign w_en_eff = w_wr_ctrl ? bus.wdata[C_CTRL_EN] : r_en;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_fsm_clr_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en_eff) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (!w_en_eff) begin
          w_state_next = ST_IDLE;
        end else begin
          w_count_next = r_preset;
          w_state_next = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!w_en_eff) begin
          w_state_next = ST_IDLE;
        end else if (r_count == 32'd0) begin
          w_state_next = ST_INT;
        end else begin
          w_count_next = r_count - 32'd1;
          if (r_count == 32'd1) w_state_next = ST_INT;
        end
      end
      ST_INT: begin
        // MODE values other than reload behave as one-shot.
        if (r_mode == C_MODE_RELOAD) begin
          w_state_next = ST_LOAD;
        end else begin
          w_fsm_clr_en = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_en     <= 1'b0;
      r_mode   <= C_MODE_ONESHOT;
      r_preset <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_wr_ctrl) begin
        r_en   <= bus.wdata[C_CTRL_EN];
        r_mode <= bus.wdata[C_CTRL_MODE_MSB:C_CTRL_MODE_LSB];
      end else if (w_fsm_clr_en) begin
        r_en <= 1'b0;
      end
      if (w_wr_preset) r_preset <= bus.wdata;
    end
  end

`ifdef TIMER_COUNTER_IRQ_EN
  logic r_im;
  logic r_pend;
  logic w_pend_set;

  // INT lasts one cycle, so a next-state of INT always marks entry.
  assign w_pend_set = (w_state_next == ST_INT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_im <= bus.wdata[C_CTRL_IM];
      if (w_pend_set) begin
        r_pend <= 1'b1;
      end else if (w_wr_ctrl || w_wr_preset) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign w_im_rd = r_im;
  assign bus.irq = r_pend & r_im;
`else
  assign w_im_rd = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      C_SEL_CTRL:   w_rdata = ctrl_pack(r_en, r_mode, w_im_rd);
      C_SEL_PRESET: w_rdata = r_preset;
      C_SEL_COUNT:  w_rdata = r_count;
      default:      w_rdata = '0;
    endcase
  end

  assign bus.rdata = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
// Module : tb_timer_counter
// Desc   : Scoreboard bench for timer_counter (irq expectations follow TIMER_COUNTER_IRQ_EN)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_counter;

`ifdef TIMER_COUNTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [31:0] IRQ_EXP = {31'd0, IRQ_ON};
  localparam logic [31:0] IM_BIT  = IRQ_ON ? 32'h8 : 32'h0;

  localparam logic [1:0] S_CTRL   = 2'd0;
  localparam logic [1:0] S_PRESET = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;
  localparam logic [1:0] S_RSVD   = 2'd3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  timer_counter_if bus();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [1:0]  sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b0; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_irq(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b1; e.sel = 2'd0; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pops every pending expectation and samples the DUT during the low clock phase.
  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_irq) begin
        got = {31'd0, bus.irq};
      end else begin
        bus.addr = {28'd0, e.sel, 2'b00};
        #1;
        got = bus.rdata;
      end
      check_value(e.tag, got, e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] be);
    bus.addr  = {28'd0, sel, 2'b00};
    bus.wdata = data;
    bus.be    = be;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    bus.be = 4'h0;
  endtask

  initial begin
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.be    = 4'h0;
    bus.wdata = '0;

    // Reset state
    step(2);
    reset = 1'b1;
    push_rd("rst_ctrl", S_CTRL, 32'h0);
    push_rd("rst_preset", S_PRESET, 32'h0);
    push_rd("rst_count", S_COUNT, 32'h0);
    push_rd("rst_rsvd", S_RSVD, 32'h0);
    push_irq("rst_irq", 32'h0);
    drain();

    // Illegal and partial writes
    wr(S_PRESET, 32'h1234_5678, 4'hF);
    wr(S_PRESET, 32'hDEAD_BEEF, 4'h3);
    wr(S_COUNT, 32'h0000_0055, 4'hF);
    wr(S_RSVD, 32'h0000_0077, 4'hF);
    wr(S_CTRL, 32'h0000_0001, 4'hE);
    step(2);
    push_rd("ill_preset", S_PRESET, 32'h1234_5678);
    push_rd("ill_count", S_COUNT, 32'h0);
    push_rd("ill_rsvd", S_RSVD, 32'h0);
    push_rd("ill_ctrl", S_CTRL, 32'h0);
    drain();

    // One-shot, PRESET=5, IM=1
    wr(S_PRESET, 32'd5, 4'hF);
    wr(S_CTRL, 32'h9, 4'hF);
    push_rd("os_pre_load", S_COUNT, 32'd0);
    drain();
    step(1);
    push_rd("os_loaded", S_COUNT, 32'd5);
    drain();
    step(4);
    push_rd("os_cnt1", S_COUNT, 32'd1);
    push_irq("os_irq_early", 32'h0);
    drain();
    step(1);
    push_rd("os_cnt0", S_COUNT, 32'd0);
    push_irq("os_irq_rise", IRQ_EXP);
    push_rd("os_ctrl_int", S_CTRL, 32'h1 | IM_BIT);
    drain();
    step(1);
    push_rd("os_en_clr", S_CTRL, IM_BIT);
    push_rd("os_cnt_hold", S_COUNT, 32'd0);
    push_irq("os_irq_hold", IRQ_EXP);
    drain();
    step(3);
    push_irq("os_irq_sticky", IRQ_EXP);
    push_rd("os_cnt_idle", S_COUNT, 32'd0);
    drain();
    wr(S_CTRL, 32'h8, 4'hF);
    push_irq("os_irq_clr", 32'h0);
    push_rd("os_ctrl_im", S_CTRL, IM_BIT);
    drain();

    // Zero preset: INT two edges after the CTRL write
    wr(S_PRESET, 32'd0, 4'hF);
    wr(S_CTRL, 32'h9, 4'hF);
    step(1);
    push_irq("zp_irq_n1", 32'h0);
    push_rd("zp_ctrl_n1", S_CTRL, 32'h1 | IM_BIT);
    drain();
    step(1);
    push_irq("zp_irq_n2", IRQ_EXP);
    push_rd("zp_ctrl_n2", S_CTRL, 32'h1 | IM_BIT);
    drain();
    step(1);
    push_rd("zp_en_clr", S_CTRL, IM_BIT);
    drain();

    // CPU CTRL write wins over the FSM clearing EN in the same cycle
    wr(S_CTRL, 32'h1, 4'hF);
    step(2);
    wr(S_CTRL, 32'h1, 4'hF);
    push_rd("prio_ctrl", S_CTRL, 32'h1);
    drain();
    wr(S_CTRL, 32'h0, 4'hF);
    push_rd("prio_stop", S_CTRL, 32'h0);
    drain();

    // Auto-reload, PRESET=3, IM=1
    wr(S_PRESET, 32'd3, 4'hF);
    wr(S_CTRL, 32'hB, 4'hF);
    push_rd("ar_ctrl", S_CTRL, 32'h3 | IM_BIT);
    drain();
    step(3);
    push_rd("ar_cnt1", S_COUNT, 32'd1);
    push_irq("ar_irq_early", 32'h0);
    drain();
    wr(S_PRESET, 32'd3, 4'hF);
    push_rd("ar_cnt0", S_COUNT, 32'd0);
    push_irq("ar_set_wins", IRQ_EXP);
    drain();
    step(2);
    push_rd("ar_reload", S_COUNT, 32'd3);
    push_irq("ar_irq_keep", IRQ_EXP);
    drain();
    step(2);
    push_rd("ar_cnt1_b", S_COUNT, 32'd1);
    drain();
    step(1);
    push_rd("ar_cnt0_b", S_COUNT, 32'd0);
    drain();
    wr(S_PRESET, 32'd3, 4'hF);
    push_irq("ar_preset_clr", 32'h0);
    drain();
    step(1);
    push_rd("ar_reload_b", S_COUNT, 32'd3);
    drain();
    wr(S_CTRL, 32'h0, 4'hF);

    // Disable mid-count, then re-enable and late PRESET update
    wr(S_PRESET, 32'd100, 4'hF);
    wr(S_CTRL, 32'h1, 4'hF);
    step(61);
    push_rd("dis_at40", S_COUNT, 32'd40);
    drain();
    wr(S_CTRL, 32'h0, 4'hF);
    push_rd("dis_frozen", S_COUNT, 32'd40);
    drain();
    step(5);
    push_rd("dis_hold", S_COUNT, 32'd40);
    push_irq("dis_irq", 32'h0);
    drain();
    wr(S_CTRL, 32'h1, 4'hF);
    step(1);
    push_rd("re_load", S_COUNT, 32'd100);
    drain();
    step(1);
    push_rd("re_dec", S_COUNT, 32'd99);
    drain();
    wr(S_PRESET, 32'd7, 4'hF);
    push_rd("pw_cnt_runs", S_COUNT, 32'd98);
    push_rd("pw_preset", S_PRESET, 32'd7);
    drain();
    wr(S_CTRL, 32'h0, 4'hF);
    push_rd("pw_stop", S_COUNT, 32'd98);
    drain();
    wr(S_CTRL, 32'h1, 4'hF);
    step(1);
    push_rd("pw_next_load", S_COUNT, 32'd7);
    drain();
    wr(S_CTRL, 32'h0, 4'hF);

    // Asynchronous reset during a running auto-reload count
    wr(S_CTRL, 32'hB, 4'hF);
    step(9);
    push_irq("ar7_irq", IRQ_EXP);
    push_rd("ar7_cnt0", S_COUNT, 32'd0);
    drain();
    step(3);
    push_rd("ar7_cnt5", S_COUNT, 32'd5);
    push_irq("ar7_irq_keep", IRQ_EXP);
    drain();
    reset = 1'b0;
    #1;
    push_rd("ar_rst_ctrl", S_CTRL, 32'h0);
    push_rd("ar_rst_preset", S_PRESET, 32'h0);
    push_rd("ar_rst_count", S_COUNT, 32'h0);
    push_rd("ar_rst_rsvd", S_RSVD, 32'h0);
    push_irq("ar_rst_irq", 32'h0);
    drain();
    step(2);
    reset = 1'b1;
    step(3);
    push_rd("post_rst_count", S_COUNT, 32'h0);
    push_rd("post_rst_ctrl", S_CTRL, 32'h0);
    push_irq("post_rst_irq", 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
